// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the four memory masters, the arbiter and the memory hub.
// Requester-side signals are 4-wide arrays: index 0=IF, 1=MEM, 2=IMMU, 3=DMMU.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 128,
  parameter int MASK_WIDTH = DATA_WIDTH/8
);
  logic [3:0]                 req_valid;
  logic [3:0]                 req_we;
  logic [3:0][ADDR_WIDTH-1:0] req_addr;
  logic [3:0][DATA_WIDTH-1:0] req_wdata;
  logic [3:0][MASK_WIDTH-1:0] req_wmask;
  logic [3:0]                 req_ready;
  logic [3:0]                 resp_valid;
  logic [DATA_WIDTH-1:0]      resp_rdata;

  logic                       mem_valid;
  logic                       mem_we;
  logic [ADDR_WIDTH-1:0]      mem_addr;
  logic [DATA_WIDTH-1:0]      mem_wdata;
  logic [MASK_WIDTH-1:0]      mem_wmask;
  logic                       mem_ready;
  logic                       mem_resp_valid;
  logic [DATA_WIDTH-1:0]      mem_rdata;

  // Arbiter side.
  modport master (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask,
    input  mem_ready, mem_resp_valid, mem_rdata,
    output req_ready, resp_valid, resp_rdata,
    output mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask
  );

  // Requesters plus memory hub.
  modport slave (
    output req_valid, req_we, req_addr, req_wdata, req_wmask,
    output mem_ready, mem_resp_valid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata,
    input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Four-way arbiter sharing one memory port; one outstanding transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin grants; default is fixed priority 3 > 2 > 1 > 0.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 128,
  parameter int MASK_WIDTH = DATA_WIDTH/8
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus,
  output logic               busy,
  output logic [1:0]         grant_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state_q;
  logic [3:0]            req_ready_q;
  logic [3:0]            resp_valid_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic                  mem_valid_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [MASK_WIDTH-1:0] mem_wmask_q;
  logic                  busy_q;
  logic [1:0]            grant_q;

  logic                  win_valid_d;
  logic [1:0]            win_id_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] rr_ptr_q;

  // Search starts one past the last grant and wraps 3 -> 0.
  always_comb begin
    win_valid_d = 1'b0;
    win_id_d    = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      if (!win_valid_d && bus.req_valid[rr_ptr_q + 2'(k)]) begin
        win_valid_d = 1'b1;
        win_id_d    = rr_ptr_q + 2'(k);
      end
    end
  end
`else
  always_comb begin
    win_valid_d = |bus.req_valid;
    win_id_d    = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (bus.req_valid[k]) win_id_d = 2'(k);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wmask_q  <= '0;
      busy_q       <= 1'b0;
      grant_q      <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr_q     <= '0;
`endif
    end else begin
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (win_valid_d) begin
            mem_we_q    <= bus.req_we[win_id_d];
            mem_addr_q  <= bus.req_addr[win_id_d];
            mem_wdata_q <= bus.req_wdata[win_id_d];
            mem_wmask_q <= bus.req_wmask[win_id_d];
            grant_q     <= win_id_d;
            req_ready_q <= 4'b0001 << win_id_d;
            mem_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr_q    <= win_id_d;
`endif
          end
        end
        ISSUE: begin
          if (bus.mem_ready) begin
            mem_valid_q <= 1'b0;
            // A response coinciding with acceptance skips WAIT entirely.
            if (bus.mem_resp_valid) begin
              resp_rdata_q <= bus.mem_rdata;
              resp_valid_q <= 4'b0001 << grant_q;
              state_q      <= RESP;
            end else begin
              state_q      <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.mem_resp_valid) begin
            resp_rdata_q <= bus.mem_rdata;
            resp_valid_q <= 4'b0001 << grant_q;
            state_q      <= RESP;
          end
        end
        RESP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_valid  = mem_valid_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_wmask  = mem_wmask_q;
  assign busy           = busy_q;
  assign grant_id       = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected grants, memory requests and
// responses; a memory responder and an output monitor pop and compare independently.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [1:0] grant_id;

  mem_port_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(128), .MASK_WIDTH(16)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(128), .MASK_WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   id;
    logic         we;
    logic [63:0]  addr;
    logic [127:0] wdata;
    logic [15:0]  wmask;
  } txn_t;

  typedef struct {
    logic [1:0]   id;
    logic [127:0] data;
  } rsp_t;

  logic [1:0] grant_q[$];
  txn_t       mem_q[$];
  rsp_t       resp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // Memory-model knobs, changed by the stimulus only while the arbiter is idle.
  int           ready_delay = 0;
  int           resp_delay  = 1;
  logic [127:0] rd_data     = '0;
  logic [127:0] last_rd     = '0;

  logic         rsp_drv    = 1'b0;
  logic [127:0] rsp_data   = '0;
  logic         stray_drv  = 1'b0;
  logic [127:0] stray_data = '0;

  assign bus.mem_resp_valid = rsp_drv | stray_drv;
  assign bus.mem_rdata      = stray_drv ? stray_data : rsp_data;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_cmp++;
    n_err++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic logic [63:0] addr_of(input int i);
    return 64'h9000_0000 + 64'(i) * 64'h100;
  endfunction

  function automatic logic [127:0] wd_of(input int i);
    return {4{32'hA5A5_0000 + 32'(i)}};
  endfunction

  task automatic set_fields(input logic [1:0] id, input logic we, input logic [63:0] addr,
                            input logic [127:0] wd, input logic [15:0] wm);
    bus.req_we[id]    = we;
    bus.req_addr[id]  = addr;
    bus.req_wdata[id] = wd;
    bus.req_wmask[id] = wm;
  endtask

  task automatic expect_txn(input logic [1:0] id, input logic we, input logic [63:0] addr,
                            input logic [127:0] wd, input logic [15:0] wm, input bit want_resp);
    txn_t t;
    rsp_t r;
    t.id = id; t.we = we; t.addr = addr; t.wdata = wd; t.wmask = wm;
    grant_q.push_back(id);
    mem_q.push_back(t);
    if (want_resp) begin
      r.id   = id;
      r.data = we ? last_rd : rd_data;
      resp_q.push_back(r);
      if (!we) last_rd = rd_data;
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus.req_ready == 4'b0 && n < 60);
    if (bus.req_ready == 4'b0) fail_now({"timeout_ready_", tag}, "req_ready stayed 0, expected a pulse");
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) fail_now({"timeout_idle_", tag}, "busy stayed 1, expected 0");
  endtask

  task automatic issue(input logic [1:0] id, input logic we, input logic [63:0] addr,
                       input logic [127:0] wd, input logic [15:0] wm, input string tag);
    set_fields(id, we, addr, wd, wm);
    expect_txn(id, we, addr, wd, wm, 1'b1);
    bus.req_valid[id] = 1'b1;
    wait_ready(tag);
    bus.req_valid[id] = 1'b0;
    wait_idle(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},  bus.req_ready,  '0);
    check({tag, "_resp_valid"}, bus.resp_valid, '0);
    check({tag, "_resp_rdata"}, bus.resp_rdata, '0);
    check({tag, "_mem_valid"},  bus.mem_valid,  '0);
    check({tag, "_mem_we"},     bus.mem_we,     '0);
    check({tag, "_mem_addr"},   bus.mem_addr,   '0);
    check({tag, "_mem_wdata"},  bus.mem_wdata,  '0);
    check({tag, "_mem_wmask"},  bus.mem_wmask,  '0);
    check({tag, "_busy"},       busy,           '0);
    check({tag, "_grant_id"},   grant_id,       '0);
  endtask

  // Output monitor: every req_ready / resp_valid pulse must match the head of its queue.
  initial begin
    logic [1:0] g;
    rsp_t       r;
    forever begin
      @(negedge clk);
      if (bus.req_ready != 4'b0) begin
        if (grant_q.size() == 0) begin
          fail_now("grant_unexpected", $sformatf("req_ready=%b with no grant expected", bus.req_ready));
        end else begin
          g = grant_q.pop_front();
          check("grant_onehot", bus.req_ready, 4'b0001 << g);
          check("grant_id", grant_id, g);
        end
      end
      if (bus.resp_valid != 4'b0) begin
        if (resp_q.size() == 0) begin
          fail_now("resp_unexpected", $sformatf("resp_valid=%b with no response expected", bus.resp_valid));
        end else begin
          r = resp_q.pop_front();
          check("resp_valid_onehot", bus.resp_valid, 4'b0001 << r.id);
          check("resp_rdata", bus.resp_rdata, r.data);
        end
      end
    end
  end

  // Memory responder: checks the issued request, holds off mem_ready, then returns a response.
  initial begin
    txn_t t;
    bus.mem_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_valid) begin
        if (mem_q.size() == 0) begin
          fail_now("mem_unexpected", "mem_valid with no request expected");
          t.id = '0; t.we = bus.mem_we; t.addr = bus.mem_addr; t.wdata = bus.mem_wdata; t.wmask = bus.mem_wmask;
        end else begin
          t = mem_q.pop_front();
          check("mem_we",    bus.mem_we,    t.we);
          check("mem_addr",  bus.mem_addr,  t.addr);
          check("mem_wdata", bus.mem_wdata, t.wdata);
          check("mem_wmask", bus.mem_wmask, t.wmask);
        end
        for (int i = 0; i < ready_delay; i++) begin
          @(posedge clk); #1;
          check("mem_valid_held",  bus.mem_valid, 1'b1);
          check("mem_addr_stable", bus.mem_addr,  t.addr);
          check("mem_wmask_stable", bus.mem_wmask, t.wmask);
        end
        bus.mem_ready = 1'b1;
        if (resp_delay == 0) begin
          rsp_drv  = 1'b1;
          rsp_data = t.we ? last_rd : rd_data;
        end
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        rsp_drv       = 1'b0;
        check("mem_valid_dropped", bus.mem_valid, 1'b0);
        if (resp_delay > 0) begin
          repeat (resp_delay - 1) begin
            @(posedge clk); #1;
          end
          rsp_drv  = 1'b1;
          rsp_data = t.we ? last_rd : rd_data;
          @(posedge clk); #1;
          rsp_drv  = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    int exp_seq[$];
    int drop3_after;

    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wmask = '0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Single IF read: req_ready one cycle after valid, resp_valid[0] in the fourth cycle.
    ready_delay = 0;
    resp_delay  = 1;
    rd_data     = 128'h1122_3344_5566_7788_9900_AABB_CCDD_EEFF;
    set_fields(2'd0, 1'b0, 64'h8000_0000, '0, '1);
    expect_txn(2'd0, 1'b0, 64'h8000_0000, '0, '1, 1'b1);
    bus.req_valid[0] = 1'b1;
    @(posedge clk); #1;
    check("if_read_req_ready_c2", bus.req_ready, 4'b0001);
    bus.req_valid[0] = 1'b0;
    @(posedge clk); #1;
    check("if_read_resp_valid_c3", bus.resp_valid, 4'b0000);
    @(posedge clk); #1;
    check("if_read_resp_valid_c4", bus.resp_valid, 4'b0001);
    check("if_read_resp_rdata_c4", bus.resp_rdata, 128'h1122_3344_5566_7788_9900_AABB_CCDD_EEFF);
    wait_idle("if_read");

    // MEM write with mem_ready held off for 3 cycles; rdata must hold the last read value.
    ready_delay = 3;
    resp_delay  = 1;
    issue(2'd1, 1'b1, 64'h8000_0010, 128'hCAFE_F00D_0000_0000_1234_5678_9ABC_DEF0, 16'h00FF, "mem_write");

    // Stray response while idle is ignored; then response coinciding with mem_ready.
    repeat (2) @(posedge clk);
    #1;
    stray_data = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
    stray_drv  = 1'b1;
    @(posedge clk); #1;
    stray_drv  = 1'b0;
    check("stray_busy", busy, 1'b0);
    check("stray_rdata_held", bus.resp_rdata, 128'h1122_3344_5566_7788_9900_AABB_CCDD_EEFF);
    ready_delay = 0;
    resp_delay  = 0;
    rd_data     = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
    issue(2'd2, 1'b0, 64'h8000_0020, '0, '1, "same_cycle_resp");

    // Grant requester 3 alone, then hold all four requesters valid.
    resp_delay = 1;
    rd_data    = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;
    issue(2'd3, 1'b0, addr_of(3), wd_of(3), '1, "prime3");
    for (int i = 0; i < 4; i++) set_fields(2'(i), 1'b0, addr_of(i), wd_of(i), '1);
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq     = '{0, 1, 2, 3, 0};
    drop3_after = -1;
`else
    exp_seq     = '{3, 3, 3, 2};
    drop3_after = 3;
`endif
    foreach (exp_seq[k]) expect_txn(2'(exp_seq[k]), 1'b0, addr_of(exp_seq[k]), wd_of(exp_seq[k]), '1, 1'b1);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < exp_seq.size(); k++) begin
      wait_ready("all_four");
      if (k + 1 == drop3_after) bus.req_valid[3] = 1'b0;
    end
    bus.req_valid = 4'b0000;
    wait_idle("all_four");

    // Requester 1 withdraws before arbitration; requester 0 must win the next grant.
    ready_delay = 3;
    set_fields(2'd0, 1'b0, addr_of(0), wd_of(0), '1);
    set_fields(2'd1, 1'b1, addr_of(1), wd_of(1), '1);
    expect_txn(2'd0, 1'b0, addr_of(0), wd_of(0), '1, 1'b1);
    expect_txn(2'd0, 1'b0, addr_of(0), wd_of(0), '1, 1'b1);
    bus.req_valid[0] = 1'b1;
    wait_ready("drop_first");
    bus.req_valid[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.req_valid[1] = 1'b0;
    wait_ready("drop_second");
    bus.req_valid[0] = 1'b0;
    wait_idle("drop");

    // Reset while waiting on a response for requester 2: aborted, no resp_valid.
    ready_delay = 0;
    resp_delay  = 6;
    rd_data     = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
    set_fields(2'd2, 1'b0, 64'h8000_0040, '0, '1);
    expect_txn(2'd2, 1'b0, 64'h8000_0040, '0, '1, 1'b0);
    bus.req_valid[2] = 1'b1;
    wait_ready("abort");
    bus.req_valid[2] = 1'b0;
    @(posedge clk); #1;
    check("abort_busy_in_wait", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("abort");
    rst     = 1'b0;
    last_rd = '0;
    repeat (10) @(posedge clk);
    #1;
    check("abort_late_resp_busy", busy, 1'b0);
    check("abort_late_resp_rdata", bus.resp_rdata, '0);
    resp_delay = 1;
    rd_data    = 128'hABCD_0123_4567_89AB_CDEF_0123_4567_89AB;
    issue(2'd2, 1'b0, 64'h8000_0050, '0, '1, "after_abort");

    repeat (5) @(posedge clk);
    #1;
    check("grant_queue_drained", grant_q.size(), 0);
    check("mem_queue_drained",   mem_q.size(),   0);
    check("resp_queue_drained",  resp_q.size(),  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
